// File: rtl/cordic_iter_core.sv
// Iterative CORDIC engine: one micro-rotation per clock, rotation and vectoring modes,
// full-circle quadrant pre-rotation, saturated x/y outputs and valid/ready on both sides.
module cordic_iter_core #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned ITER    = 16,
    parameter int unsigned ANGLE_W = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      mode,
    input  logic signed [WIDTH-1:0]   x_in,
    input  logic signed [WIDTH-1:0]   y_in,
    input  logic        [ANGLE_W-1:0] z_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [WIDTH-1:0]   x_out,
    output logic signed [WIDTH-1:0]   y_out,
    output logic        [ANGLE_W-1:0] z_out,
    output logic                      sat
);

    localparam int unsigned IW = WIDTH + 2;
    localparam int unsigned CW = 5;

    localparam logic        [ANGLE_W-1:0] Quarter = {2'b01, {(ANGLE_W - 2){1'b0}}};
    localparam logic signed [IW-1:0]      SatMax  = {3'b000, {(WIDTH - 1){1'b1}}};
    localparam logic signed [IW-1:0]      SatMin  = {3'b111, {(WIDTH - 1){1'b0}}};
    localparam logic        [CW-1:0]      LastIt  = CW'(ITER - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                 state_q, state_d;
    logic signed [IW-1:0]   x_q, x_d, y_q, y_d;
    logic [ANGLE_W-1:0]     z_q, z_d;
    logic [CW-1:0]          iter_q, iter_d;
    logic                   mode_q, mode_d;
    logic signed [WIDTH-1:0] x_out_q, x_out_d, y_out_q, y_out_d;
    logic [ANGLE_W-1:0]     z_out_q, z_out_d;
    logic                   sat_q, sat_d;

    logic signed [IW-1:0]   x_ext, y_ext, pre_x, pre_y;
    logic [ANGLE_W-1:0]     pre_z;
    logic signed [IW-1:0]   x_shr, y_shr, x_nxt, y_nxt;
    logic [ANGLE_W-1:0]     z_nxt, atan_i;
    logic                   dir_pos;
    logic                   x_hi, x_lo, y_hi, y_lo;
    logic signed [WIDTH-1:0] x_clip, y_clip;

    // round(atan(2^-i) * 2^32 / 360deg)
    function automatic logic [31:0] atan_lut(input logic [CW-1:0] idx);
        logic [31:0] v;
        v = 32'h0;
        case (idx)
            5'd0:  v = 32'h20000000;
            5'd1:  v = 32'h12E4051E;
            5'd2:  v = 32'h09FB385B;
            5'd3:  v = 32'h051111D4;
            5'd4:  v = 32'h028B0D43;
            5'd5:  v = 32'h0145D7E1;
            5'd6:  v = 32'h00A2F61E;
            5'd7:  v = 32'h00517C55;
            5'd8:  v = 32'h0028BE53;
            5'd9:  v = 32'h00145F2F;
            5'd10: v = 32'h000A2F98;
            5'd11: v = 32'h000517CC;
            5'd12: v = 32'h00028BE6;
            5'd13: v = 32'h000145F3;
            5'd14: v = 32'h0000A2FA;
            5'd15: v = 32'h0000517D;
            5'd16: v = 32'h000028BE;
            5'd17: v = 32'h0000145F;
            5'd18: v = 32'h00000A30;
            5'd19: v = 32'h00000518;
            5'd20: v = 32'h0000028C;
            5'd21: v = 32'h00000146;
            5'd22: v = 32'h000000A3;
            5'd23: v = 32'h00000051;
            5'd24: v = 32'h00000029;
            5'd25: v = 32'h00000014;
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    // Quadrant pre-rotation brings the vector into the CORDIC convergence range.
    always_comb begin
        x_ext = {{2{x_in[WIDTH-1]}}, x_in};
        y_ext = {{2{y_in[WIDTH-1]}}, y_in};
        pre_x = x_ext;
        pre_y = y_ext;
        pre_z = z_in;
        if (!mode) begin
            case (z_in[ANGLE_W-1 -: 2])
                2'b01: begin
                    pre_x = -y_ext;
                    pre_y = x_ext;
                    pre_z = z_in - Quarter;
                end
                2'b10: begin
                    pre_x = y_ext;
                    pre_y = -x_ext;
                    pre_z = z_in + Quarter;
                end
                default: ;
            endcase
        end else if (x_ext[IW-1]) begin
            if (!y_ext[IW-1]) begin
                pre_x = y_ext;
                pre_y = -x_ext;
                pre_z = z_in + Quarter;
            end else begin
                pre_x = -y_ext;
                pre_y = x_ext;
                pre_z = z_in - Quarter;
            end
        end
    end

    always_comb begin
        x_shr   = x_q >>> iter_q;
        y_shr   = y_q >>> iter_q;
        atan_i  = atan_lut(iter_q);
        dir_pos = mode_q ? y_q[IW-1] : ~z_q[ANGLE_W-1];
        if (dir_pos) begin
            x_nxt = x_q - y_shr;
            y_nxt = y_q + x_shr;
            z_nxt = z_q - atan_i;
        end else begin
            x_nxt = x_q + y_shr;
            y_nxt = y_q - x_shr;
            z_nxt = z_q + atan_i;
        end
    end

    always_comb begin
        x_hi   = x_nxt > SatMax;
        x_lo   = x_nxt < SatMin;
        y_hi   = y_nxt > SatMax;
        y_lo   = y_nxt < SatMin;
        x_clip = x_hi ? SatMax[WIDTH-1:0] : (x_lo ? SatMin[WIDTH-1:0] : x_nxt[WIDTH-1:0]);
        y_clip = y_hi ? SatMax[WIDTH-1:0] : (y_lo ? SatMin[WIDTH-1:0] : y_nxt[WIDTH-1:0]);
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        z_d       = z_q;
        iter_d    = iter_q;
        mode_d    = mode_q;
        x_out_d   = x_out_q;
        y_out_d   = y_out_q;
        z_out_d   = z_out_q;
        sat_d     = sat_q;
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    x_d     = pre_x;
                    y_d     = pre_y;
                    z_d     = pre_z;
                    mode_d  = mode;
                    iter_d  = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                x_d    = x_nxt;
                y_d    = y_nxt;
                z_d    = z_nxt;
                iter_d = iter_q + 5'd1;
                if (iter_q == LastIt) begin
                    x_out_d = x_clip;
                    y_out_d = y_clip;
                    z_out_d = z_nxt;
                    sat_d   = x_hi | x_lo | y_hi | y_lo;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            iter_q  <= '0;
            mode_q  <= 1'b0;
            x_out_q <= '0;
            y_out_q <= '0;
            z_out_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            iter_q  <= iter_d;
            mode_q  <= mode_d;
            x_out_q <= x_out_d;
            y_out_q <= y_out_d;
            z_out_q <= z_out_d;
            sat_q   <= sat_d;
        end
    end

    assign x_out = x_out_q;
    assign y_out = y_out_q;
    assign z_out = z_out_q;
    assign sat   = sat_q;

endmodule

// File: tb/tb_cordic_iter_core.sv
// Directed bench for cordic_iter_core (WIDTH=16, ITER=16): vector table plus
// backpressure and mid-run reset sequences.
module tb_cordic_iter_core;

    localparam int unsigned WIDTH   = 16;
    localparam int unsigned ITER    = 16;
    localparam int unsigned ANGLE_W = 32;
    localparam longint      ZTol    = 64'd1 << 20;
    // Truncating shifts leave a few LSB of bias against the ideal K*rotation.
    localparam longint      XyTol   = 6;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      in_valid;
    logic                      in_ready;
    logic                      mode;
    logic signed [WIDTH-1:0]   x_in;
    logic signed [WIDTH-1:0]   y_in;
    logic        [ANGLE_W-1:0] z_in;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [WIDTH-1:0]   x_out;
    logic signed [WIDTH-1:0]   y_out;
    logic        [ANGLE_W-1:0] z_out;
    logic                      sat;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic        m;
        int          xi;
        int          yi;
        logic [31:0] zi;
        int          ex;
        int          ey;
        logic [31:0] ez;
        longint      tol;
        logic        esat;
    } vec_t;

    vec_t vecs[9];

    cordic_iter_core #(
        .WIDTH  (WIDTH),
        .ITER   (ITER),
        .ANGLE_W(ANGLE_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mode     (mode),
        .x_in     (x_in),
        .y_in     (y_in),
        .z_in     (z_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .x_out    (x_out),
        .y_out    (y_out),
        .z_out    (z_out),
        .sat      (sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp,
                         input longint tol);
        longint diff;
        total++;
        diff = act - exp;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (tol %0d)", name, act, exp, tol);
        end
    endtask

    task automatic check_z(input string name, input logic [31:0] exp);
        logic signed [31:0] dz;
        dz = z_out - exp;
        check(name, longint'(dz), 0, ZTol);
    endtask

    // Issue one transform and wait for out_valid; returns edges from accept to valid.
    task automatic start_op(input logic m, input int xi, input int yi, input logic [31:0] zi,
                            output int lat);
        @(negedge clk);
        mode     = m;
        x_in     = 16'(xi);
        y_in     = 16'(yi);
        z_in     = zi;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x_in     = 16'sd0;
        y_in     = 16'sd0;
        z_in     = 32'h0;
        lat      = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic finish_op(input string name);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, ".valid_drop"}, longint'(out_valid), 0, 0);
        check({name, ".ready_back"}, longint'(in_ready), 1, 0);
    endtask

    task automatic apply(input vec_t v);
        int lat;
        check({v.name, ".ready_pre"}, longint'(in_ready), 1, 0);
        start_op(v.m, v.xi, v.yi, v.zi, lat);
        check({v.name, ".latency"}, longint'(lat), longint'(ITER), 0);
        check({v.name, ".x"}, longint'(x_out), longint'(v.ex), v.tol);
        check({v.name, ".y"}, longint'(y_out), longint'(v.ey), v.tol);
        check_z({v.name, ".z"}, v.ez);
        check({v.name, ".sat"}, longint'(sat), longint'(v.esat), 0);
        finish_op(v.name);
    endtask

    initial begin
        int lat;
        int seen;

        // x_in=19429 ~= 32000/K; ideal results are K*|v| with K=1.646760.
        vecs[0] = '{"rot45",  1'b0, 19429,  0,      32'h20000000, 22624,  22624,  32'h0,
                    XyTol, 1'b0};
        vecs[1] = '{"rot60",  1'b0, 19429,  0,      32'h2AAAAAAA, 15997,  27708,  32'h0,
                    XyTol, 1'b0};
        vecs[2] = '{"rot90",  1'b0, 19429,  0,      32'h40000000, 0,      31995,  32'h0,
                    XyTol, 1'b0};
        vecs[3] = '{"rot135", 1'b0, 19429,  0,      32'h60000000, -22624, 22624,  32'h0,
                    XyTol, 1'b0};
        vecs[4] = '{"rot225", 1'b0, 19429,  0,      32'hA0000000, -22624, -22624, 32'h0,
                    XyTol, 1'b0};
        vecs[5] = '{"rot270", 1'b0, 19429,  0,      32'hC0000000, 0,      -31995, 32'h0,
                    XyTol, 1'b0};
        vecs[6] = '{"vec_q2", 1'b1, -10000, 10000,  32'h0,        23289,  0,
                    32'h60000000, XyTol, 1'b0};
        vecs[7] = '{"vec_q3", 1'b1, -10000, -10000, 32'h0,        23289,  0,
                    32'hA0000000, XyTol, 1'b0};
        vecs[8] = '{"sat45",  1'b0, 32767,  0,      32'h20000000, 32767,  32767,  32'h0,
                    0, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mode      = 1'b0;
        x_in      = 16'sd0;
        y_in      = 16'sd0;
        z_in      = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.in_ready", longint'(in_ready), 1, 0);
        check("reset.out_valid", longint'(out_valid), 0, 0);
        check("reset.x", longint'(x_out), 0, 0);
        check("reset.y", longint'(y_out), 0, 0);
        check("reset.z", longint'(z_out), 0, 0);
        check("reset.sat", longint'(sat), 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            apply(vecs[i]);
        end

        // Backpressure: result held 5 cycles; an in_valid pulse inside is ignored.
        start_op(1'b0, 19429, 0, 32'h20000000, lat);
        check("bp.latency", longint'(lat), longint'(ITER), 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = (k == 2);
            mode     = 1'b1;
            x_in     = 16'sd1000;
            y_in     = -16'sd1000;
            z_in     = 32'h12345678;
            @(posedge clk);
            #1;
            check($sformatf("bp.valid%0d", k), longint'(out_valid), 1, 0);
            check($sformatf("bp.busy%0d", k), longint'(in_ready), 0, 0);
            check($sformatf("bp.x%0d", k), longint'(x_out), 22624, XyTol);
            check($sformatf("bp.y%0d", k), longint'(y_out), 22624, XyTol);
        end
        @(negedge clk);
        in_valid = 1'b0;
        finish_op("bp");
        @(posedge clk);
        #1;
        check("bp.still_idle", longint'(in_ready), 1, 0);
        check("bp.no_result", longint'(out_valid), 0, 0);
        check("bp.x_kept", longint'(x_out), 22624, XyTol);
        check("bp.y_kept", longint'(y_out), 22624, XyTol);

        // Reset at iteration 7 discards the operation; in_valid during reset is dropped.
        @(negedge clk);
        mode     = 1'b0;
        x_in     = 16'sd19429;
        y_in     = 16'sd0;
        z_in     = 32'h2AAAAAAA;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("rst.in_ready", longint'(in_ready), 1, 0);
        check("rst.out_valid", longint'(out_valid), 0, 0);
        check("rst.x", longint'(x_out), 0, 0);
        check("rst.y", longint'(y_out), 0, 0);
        check("rst.z", longint'(z_out), 0, 0);
        check("rst.sat", longint'(sat), 0, 0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        seen     = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("rst.no_valid", longint'(seen), 0, 0);
        apply(vecs[1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
